// File: rtl/ula_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states and flag bit positions.
package ula_pkg;

    localparam logic [3:0] ULA_AND   = 4'd0;
    localparam logic [3:0] ULA_OR    = 4'd1;
    localparam logic [3:0] ULA_ADD   = 4'd2;
    localparam logic [3:0] ULA_XOR   = 4'd3;
    localparam logic [3:0] ULA_SLL   = 4'd4;
    localparam logic [3:0] ULA_SRL   = 4'd5;
    localparam logic [3:0] ULA_SUB   = 4'd6;
    localparam logic [3:0] ULA_SLT   = 4'd7;
    localparam logic [3:0] ULA_SRA   = 4'd8;
    localparam logic [3:0] ULA_SLTU  = 4'd9;
    localparam logic [3:0] ULA_MULTU = 4'd10;
    localparam logic [3:0] ULA_DIVU  = 4'd11;
    localparam logic [3:0] ULA_NOR   = 4'd12;
    localparam logic [3:0] ULA_MFHI  = 4'd13;
    localparam logic [3:0] ULA_MFLO  = 4'd14;
    localparam logic [3:0] ULA_ILEG  = 4'd15;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MULT   = 2'd1,
        DIV    = 2'd2,
        FIM    = 2'd3
    } estado_t;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_OVF  = 1;
    localparam int FLAG_DZ   = 2;
    localparam int FLAG_W    = 3;

endpackage

// File: rtl/ula_mult_div.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle.
// The divider half exists only when ULA_DIVISAO_EN is defined.
module ula_mult_div
    import ula_pkg::*;
#(
    parameter int LARGURA = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [LARGURA-1:0] a,
    input  logic [LARGURA-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo
);

    localparam int CW = $clog2(LARGURA) + 1;

    // acc holds {product high, multiplier/product low} or {remainder, dividend/quotient}
    logic [2*LARGURA-1:0] acc_q, acc_d, passo;
    logic [LARGURA-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [LARGURA:0]     soma;

`ifdef ULA_DIVISAO_EN
    logic             div_q, div_d;
    logic [LARGURA:0] parc, dif;
`else
    logic unused_op;
    assign unused_op = op;
`endif

    always_comb begin
        soma  = {1'b0, acc_q[2*LARGURA-1:LARGURA]} + {1'b0, (acc_q[0] ? opnd_q : {LARGURA{1'b0}})};
        passo = {soma, acc_q[LARGURA-1:1]};
`ifdef ULA_DIVISAO_EN
        parc = {acc_q[2*LARGURA-1:LARGURA], acc_q[LARGURA-1]};
        dif  = parc - {1'b0, opnd_q};
        if (div_q) begin
            // borrow out of the trial subtraction means the partial remainder is restored
            passo = dif[LARGURA] ? {parc[LARGURA-1:0], acc_q[LARGURA-2:0], 1'b0}
                                 : {dif[LARGURA-1:0],  acc_q[LARGURA-2:0], 1'b1};
        end
`endif
    end

    always_comb begin
        acc_d  = acc_q;
        opnd_d = opnd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
`ifdef ULA_DIVISAO_EN
        div_d  = div_q;
`endif
        if (start && !busy_q) begin
            busy_d = 1'b1;
            cnt_d  = CW'(LARGURA);
`ifdef ULA_DIVISAO_EN
            div_d  = op;
            opnd_d = op ? b : a;
            acc_d  = {{LARGURA{1'b0}}, (op ? a : b)};
`else
            opnd_d = a;
            acc_d  = {{LARGURA{1'b0}}, b};
`endif
        end else if (busy_q) begin
            acc_d = passo;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc_q  <= '0;
            opnd_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef ULA_DIVISAO_EN
            div_q  <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            opnd_q <= opnd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
`ifdef ULA_DIVISAO_EN
            div_q  <= div_d;
`endif
        end
    end

    // Result is presented during the final iteration so the caller commits it on that edge.
    assign busy = busy_q;
    assign done = busy_q && (cnt_q == CW'(1));
    assign hi   = passo[2*LARGURA-1:LARGURA];
    assign lo   = passo[LARGURA-1:0];

endmodule

// File: rtl/ula_multiciclo.sv
// EX-stage ALU with single-cycle ops, registered flags and an iterative MULTU/DIVU engine.
// DIVU is available only when ULA_DIVISAO_EN is defined; otherwise code 11 is illegal.
//
// state  | meaning
// OCIOSO | idle, accepts iniciar
// MULT   | multiply iterating, ocupado=1
// DIV    | divide iterating, ocupado=1
// FIM    | pronto cycle of a multi-cycle op, accepts iniciar like OCIOSO
module ula_multiciclo
    import ula_pkg::*;
#(
    parameter int LARGURA = 32,
    parameter int SHW     = $clog2(LARGURA)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [3:0]         ctrlULA,
    input  logic [LARGURA-1:0] entradaA,
    input  logic [LARGURA-1:0] entradaB,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] saida,
    output logic               zero,
    output logic               overflow,
    output logic               div_zero,
    output logic [LARGURA-1:0] hi,
    output logic [LARGURA-1:0] lo
);

    estado_t              estado_q, estado_d;
    logic [LARGURA-1:0]   saida_q, saida_d;
    logic [LARGURA-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [FLAG_W-1:0]    flags_q, flags_d;
    logic                 pronto_q, pronto_d;

    logic                 inicia_eng, eng_busy, eng_done;
    logic [LARGURA-1:0]   eng_hi, eng_lo;
    logic [LARGURA-1:0]   res, soma, dif;
    logic                 ovf_res;
    logic [SHW-1:0]       sh;

    ula_mult_div #(.LARGURA(LARGURA)) u_mult_div (
        .clock (clock),
        .reset (reset),
        .start (inicia_eng),
        .op    (ctrlULA == ULA_DIVU),
        .a     (entradaA),
        .b     (entradaB),
        .busy  (eng_busy),
        .done  (eng_done),
        .hi    (eng_hi),
        .lo    (eng_lo)
    );

    always_comb begin
        soma    = entradaA + entradaB;
        dif     = entradaA - entradaB;
        sh      = entradaB[SHW-1:0];
        res     = '0;
        ovf_res = 1'b0;
        case (ctrlULA)
            ULA_AND:  res = entradaA & entradaB;
            ULA_OR:   res = entradaA | entradaB;
            ULA_ADD: begin
                res     = soma;
                ovf_res = (entradaA[LARGURA-1] == entradaB[LARGURA-1]) &&
                          (soma[LARGURA-1] != entradaA[LARGURA-1]);
            end
            ULA_XOR:  res = entradaA ^ entradaB;
            ULA_SLL:  res = entradaA << sh;
            ULA_SRL:  res = entradaA >> sh;
            ULA_SUB: begin
                res     = dif;
                ovf_res = (entradaA[LARGURA-1] != entradaB[LARGURA-1]) &&
                          (dif[LARGURA-1] != entradaA[LARGURA-1]);
            end
            ULA_SLT:  res[0] = $signed(entradaA) < $signed(entradaB);
            ULA_SRA:  res = $signed(entradaA) >>> sh;
            ULA_SLTU: res[0] = entradaA < entradaB;
            ULA_NOR:  res = ~(entradaA | entradaB);
            ULA_MFHI: res = hi_q;
            ULA_MFLO: res = lo_q;
            default:  res = '0;
        endcase
    end

    always_comb begin
        estado_d   = estado_q;
        saida_d    = saida_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        flags_d    = flags_q;
        pronto_d   = 1'b0;
        inicia_eng = 1'b0;
        case (estado_q)
            OCIOSO, FIM: begin
                estado_d = OCIOSO;
                if (iniciar) begin
                    if (ctrlULA == ULA_MULTU) begin
                        inicia_eng = 1'b1;
                        estado_d   = MULT;
`ifdef ULA_DIVISAO_EN
                    end else if (ctrlULA == ULA_DIVU && entradaB == '0) begin
                        lo_d               = '1;
                        hi_d               = entradaA;
                        saida_d            = '1;
                        flags_d            = '0;
                        flags_d[FLAG_DZ]   = 1'b1;
                        pronto_d           = 1'b1;
                    end else if (ctrlULA == ULA_DIVU) begin
                        inicia_eng = 1'b1;
                        estado_d   = DIV;
`endif
                    end else begin
                        // without the divider, DIVU falls through here with res=0
                        saida_d            = res;
                        flags_d            = '0;
                        flags_d[FLAG_ZERO] = (res == '0);
                        flags_d[FLAG_OVF]  = ovf_res;
                        pronto_d           = 1'b1;
                    end
                end
            end
            MULT, DIV: begin
                if (eng_done) begin
                    hi_d               = eng_hi;
                    lo_d               = eng_lo;
                    saida_d            = eng_lo;
                    flags_d            = '0;
                    flags_d[FLAG_ZERO] = (eng_lo == '0);
                    pronto_d           = 1'b1;
                    estado_d           = FIM;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            saida_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            flags_q  <= FLAG_W'(1) << FLAG_ZERO;
            pronto_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            saida_q  <= saida_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            flags_q  <= flags_d;
            pronto_q <= pronto_d;
        end
    end

    assign ocupado  = eng_busy;
    assign pronto   = pronto_q;
    assign saida    = saida_q;
    assign zero     = flags_q[FLAG_ZERO];
    assign overflow = flags_q[FLAG_OVF];
    assign div_zero = flags_q[FLAG_DZ];
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
